// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_e;

    localparam int   PRESC_MIN    = 4;
    localparam int   DATA_LEN_MIN = 5;
    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Three-sample capture around mid-bit and 2-of-3 majority vote with a decision strobe.
module uart_rx_vote
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_rx,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic [PRESC_W-1:0] i_edg,
    output logic               o_bit,
    output logic               o_dec
);

    logic [PRESC_W-1:0] w_mid;
    logic [PRESC_W-1:0] w_lo;
    logic [PRESC_W-1:0] w_hi;
    logic [PRESC_W-1:0] w_dec_pt;
    logic               w_late;
    logic [2:0]         r_smp;

    assign w_mid    = i_presc >> 1;
    assign w_lo     = w_mid - PRESC_W'(1);
    assign w_hi     = w_mid + PRESC_W'(1);
    assign w_dec_pt = w_mid + PRESC_W'(2);
    // At the minimum prescale mid+2 lies past the bit end, so vote on the live third sample.
    assign w_late   = (w_dec_pt >= i_presc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp <= '0;
        end else if (i_en) begin
            if (i_edg == w_lo)  r_smp[0] <= i_rx;
            if (i_edg == w_mid) r_smp[1] <= i_rx;
            if (i_edg == w_hi)  r_smp[2] <= i_rx;
        end
    end

    assign o_dec = i_en && (i_edg == (w_late ? w_hi : w_dec_pt));
    assign o_bit = maj3(r_smp[0], r_smp[1], w_late ? i_rx : r_smp[2]);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive controller: start detect, voted bit recovery, deserialise, parity/stop/break checks.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W_MAX = 8,
    parameter int PRESC_W    = 6
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_in,
    input  logic [PRESC_W-1:0]    i_prescale,
    input  logic [3:0]            i_data_len,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    input  logic                  i_stop2,
    output logic [DATA_W_MAX-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_str_err,
    output logic                  o_par_err,
    output logic                  o_stp_err,
    output logic                  o_brk_det,
    output logic                  o_busy
);

    rx_state_e             r_state;
    rx_state_e             w_next;
    logic [PRESC_W-1:0]    r_edg;
    logic [PRESC_W-1:0]    r_presc;
    logic [PRESC_W-1:0]    w_presc_eff;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            r_len;
    logic [3:0]            w_len_eff;
    logic                  r_par_en;
    logic                  r_par_odd;
    logic                  r_stop2;
    logic [DATA_W_MAX-1:0] r_shift;
    logic                  r_par_bad;
    logic                  r_stp_bad;
    logic                  r_zero;
    logic [DATA_W_MAX-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_str_err;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_brk_det;
    logic                  w_bit;
    logic                  w_dec;
    logic                  w_wrap;
    logic                  w_start;
    logic                  w_active;
    logic                  w_false_start;
    logic                  w_frame_end;
    logic                  w_stp_bad;
    logic                  w_zero;

    assign w_presc_eff = (i_prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : i_prescale;
    assign w_len_eff   = (i_data_len < 4'(DATA_LEN_MIN) || i_data_len > 4'(DATA_W_MAX))
                         ? 4'(DATA_W_MAX) : i_data_len;
    assign w_wrap      = (r_edg == r_presc - PRESC_W'(1));
    assign w_start     = (r_state == ST_IDLE) && !i_rx_in;

    uart_rx_vote #(.PRESC_W(PRESC_W)) u_vote (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_active),
        .i_rx    (i_rx_in),
        .i_presc (r_presc),
        .i_edg   (r_edg),
        .o_bit   (w_bit),
        .o_dec   (w_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Frame end is the final stop decision, not the bit boundary, so a prompt next start is caught.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!i_rx_in) w_next = ST_START;
            ST_START:  if (w_dec && w_bit) w_next = ST_IDLE;
                       else if (w_wrap)    w_next = ST_DATA;
            ST_DATA:   if (w_wrap && r_bit_cnt == r_len) w_next = r_par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (w_wrap) w_next = ST_STOP1;
            ST_STOP1:  if (w_dec && !r_stop2) w_next = ST_IDLE;
                       else if (w_wrap)       w_next = ST_STOP2;
            ST_STOP2:  if (w_dec) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_active      = (r_state != ST_IDLE);
        o_busy        = w_active;
        w_false_start = (r_state == ST_START) && w_dec && w_bit;
        w_frame_end   = w_dec && ((r_state == ST_STOP1 && !r_stop2) || r_state == ST_STOP2);
        w_stp_bad     = r_stp_bad | ~w_bit;
        w_zero        = r_zero & ~w_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edg     <= '0;
            r_bit_cnt <= '0;
            r_presc   <= PRESC_W'(PRESC_MIN);
            r_len     <= 4'(DATA_W_MAX);
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_edg     <= '0;
            r_bit_cnt <= '0;
            if (!i_rx_in) begin
                r_presc   <= w_presc_eff;
                r_len     <= w_len_eff;
                r_par_en  <= i_par_en;
                r_par_odd <= i_par_odd;
                r_stop2   <= i_stop2;
            end
        end else if (w_wrap) begin
            r_edg     <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
            r_edg     <= r_edg + PRESC_W'(1);
        end
    end

    // r_zero tracks "every bit after start was 0" for break detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_stp_bad <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_start) begin
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_stp_bad <= 1'b0;
            r_zero    <= 1'b1;
        end else if (w_dec) begin
            case (r_state)
                ST_DATA: begin
                    for (int i = 0; i < DATA_W_MAX; i++)
                        if (r_bit_cnt == 4'(i + 1)) r_shift[i] <= w_bit;
                    r_zero <= w_zero;
                end
                ST_PARITY: begin
                    r_par_bad <= w_bit ^ (^r_shift) ^ (r_par_odd == PAR_ODD);
                    r_zero    <= w_zero;
                end
                ST_STOP1, ST_STOP2: begin
                    r_stp_bad <= w_stp_bad;
                    r_zero    <= w_zero;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_str_err  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            r_brk_det  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_str_err  <= w_false_start;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            r_brk_det  <= 1'b0;
            if (w_frame_end) begin
                r_par_err <= r_par_bad;
                r_stp_err <= w_stp_bad;
                r_brk_det <= w_zero;
                if (!r_par_bad && !w_stp_bad) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_shift;
                end
            end
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_str_err  = r_str_err;
    assign o_par_err  = r_par_err;
    assign o_stp_err  = r_stp_err;
    assign o_brk_det  = r_brk_det;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a frame-level reference model checked every cycle.
module tb_uart_rx_frame_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [PW-1:0] presc = 6'd16;
    logic [3:0]    len = 4'd8;
    logic          pe = 1'b0, po = 1'b0, s2 = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, str_err, par_err, stp_err, brk_det, busy;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DATA_W_MAX(DW), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_in    (rx),
        .i_prescale (presc),
        .i_data_len (len),
        .i_par_en   (pe),
        .i_par_odd  (po),
        .i_stop2    (s2),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_str_err  (str_err),
        .o_par_err  (par_err),
        .o_stp_err  (stp_err),
        .o_brk_det  (brk_det),
        .o_busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame by its offset from the first busy cycle.
    bit          m_in = 0;
    int          m_off, m_P, m_len, m_nb;
    bit          m_pe, m_po, m_s2;
    bit [2:0]    m_s;
    bit          m_bits [0:15];
    logic        e_busy = 0, e_val = 0, e_str = 0, e_par = 0, e_stp = 0, e_brk = 0;
    logic [7:0]  e_data = 0;
    int          n_val = 0, n_str = 0, n_par = 0, n_stp = 0, n_brk = 0;
    int          busy_run = 0, last_run = 0;
    logic [7:0]  val_q [$];

    always @(negedge clk) begin : mon
        int mid, edg, bi;
        logic [7:0] d;
        bit pbad, sbad, zero;
        if (!rst) begin
            check("reset_outs", {18'd0, busy, rx_valid, str_err, par_err, stp_err, brk_det, rx_data}, 32'd0);
            m_in = 0; e_busy = 0; e_val = 0; e_str = 0; e_par = 0; e_stp = 0; e_brk = 0; e_data = 0;
            busy_run = 0;
        end else begin
            check("outs{busy,val,str,par,stp,brk,data}",
                  {18'd0, busy, rx_valid, str_err, par_err, stp_err, brk_det, rx_data},
                  {18'd0, e_busy, e_val, e_str, e_par, e_stp, e_brk, e_data});
            if (rx_valid) begin n_val++; val_q.push_back(rx_data); end
            if (str_err) n_str++;
            if (par_err) n_par++;
            if (stp_err) n_stp++;
            if (brk_det) n_brk++;
            if (busy) busy_run++;
            else if (busy_run != 0) begin last_run = busy_run; busy_run = 0; end
            e_val = 0; e_str = 0; e_par = 0; e_stp = 0; e_brk = 0;
            if (!m_in) begin
                if (rx == 1'b0) begin
                    m_in  = 1; m_off = 0;
                    m_P   = (presc < 4) ? 4 : int'(presc);
                    m_len = (len < 5 || len > 8) ? 8 : int'(len);
                    m_pe  = pe; m_po = po; m_s2 = s2;
                    m_nb  = 2 + m_len + int'(m_pe) + int'(m_s2);
                end
            end else begin
                mid = m_P / 2; edg = m_off % m_P; bi = m_off / m_P;
                if (edg >= mid - 1 && edg <= mid + 1) m_s[edg - mid + 1] = rx;
                if (edg == mid + 2) begin
                    m_bits[bi] = (int'(m_s[0]) + int'(m_s[1]) + int'(m_s[2])) >= 2;
                    if (bi == 0 && m_bits[0]) begin
                        e_str = 1; m_in = 0;
                    end else if (bi == m_nb - 1) begin
                        d = 0;
                        for (int i = 0; i < m_len; i++) d[i] = m_bits[1 + i];
                        pbad = m_pe && (m_bits[1 + m_len] != ((^d) ^ m_po));
                        sbad = 0; zero = 1;
                        for (int i = 1; i < m_nb; i++) if (m_bits[i]) zero = 0;
                        for (int i = 1 + m_len + int'(m_pe); i < m_nb; i++) if (!m_bits[i]) sbad = 1;
                        e_par = pbad; e_stp = sbad; e_brk = zero;
                        if (!pbad && !sbad) begin e_val = 1; e_data = d; end
                        m_in = 0;
                    end
                end
                m_off++;
            end
            e_busy = m_in;
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives one frame; lcfg is the data_len input, L the number of data bits actually sent.
    task automatic send(input logic [8:0] d, input int P, input int L, input int lcfg,
                        input bit p_en, input bit p_odd, input bit two, input bit p_flip,
                        input bit last_stop, input bit glitch);
        logic [15:0] b;
        int nb, mid;
        logic par;
        presc = PW'(P); len = 4'(lcfg); pe = p_en; po = p_odd; s2 = two;
        b = '0; nb = 1; par = p_odd ^ p_flip;
        for (int i = 0; i < L; i++) begin b[nb] = d[i]; par = par ^ d[i]; nb++; end
        if (p_en) begin b[nb] = par; nb++; end
        b[nb] = two ? 1'b1 : last_stop; nb++;
        if (two) begin b[nb] = last_stop; nb++; end
        mid = P / 2;
        for (int k = 0; k < nb; k++) begin
            if (glitch && k >= 1 && k <= L) begin
                hold(b[k], mid + 1); hold(~b[k], 1); hold(b[k], P - mid - 2);
            end else begin
                hold(b[k], P);
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 4000) begin @(posedge clk); #1; k++; end
        check("idle_wait_busy", {31'd0, busy}, 32'd0);
    endtask

    int v0, s0, p0, t0, b0, q0;

    initial begin
        rst = 1'b0;
        hold(1, 3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b1;
        hold(1, 5);

        // 0xA5, P=16, 8N1; busy spans the detect cycle through the stop decision
        v0 = n_val; s0 = n_str; p0 = n_par; t0 = n_stp; b0 = n_brk;
        send(9'h0A5, 16, 8, 8, 0, 0, 0, 0, 1, 0);
        hold(1, 20); wait_idle();
        check("a5_valid_cnt", n_val - v0, 1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_err_cnt", (n_str - s0) + (n_par - p0) + (n_stp - t0) + (n_brk - b0), 0);
        check("a5_busy_len", last_run, 9 * 16 + 10 + 1);

        // P=8, 7 bits, odd parity: good then flipped parity bit
        v0 = n_val; p0 = n_par;
        send(9'h03C, 8, 7, 7, 1, 1, 0, 0, 1, 0);
        hold(1, 10); wait_idle();
        check("p3c_valid_cnt", n_val - v0, 1);
        check("p3c_data", {24'd0, rx_data}, 32'h3C);
        send(9'h03C, 8, 7, 7, 1, 1, 0, 1, 1, 0);
        hold(1, 10); wait_idle();
        check("p3c_flip_par_cnt", n_par - p0, 1);
        check("p3c_flip_valid_cnt", n_val - v0, 1);
        check("p3c_flip_data_hold", {24'd0, rx_data}, 32'h3C);

        // false start: 3-clock low pulse
        v0 = n_val; s0 = n_str;
        presc = 6'd16; len = 4'd8; pe = 0; s2 = 0;
        hold(0, 3); hold(1, 40); wait_idle();
        check("false_start_cnt", n_str - s0, 1);
        check("false_start_valid", n_val - v0, 0);

        // two stop bits, second stop 0
        v0 = n_val; p0 = n_par; t0 = n_stp; b0 = n_brk;
        send(9'h081, 16, 8, 8, 0, 0, 1, 0, 0, 0);
        hold(1, 20); wait_idle();
        check("stop2_stp_cnt", n_stp - t0, 1);
        check("stop2_other_cnt", (n_val - v0) + (n_par - p0) + (n_brk - b0), 0);

        // break: low for 12 bit-times (a second frame starts while still low)
        t0 = n_stp; b0 = n_brk;
        presc = 6'd16; len = 4'd8; pe = 0; po = 0; s2 = 1;
        hold(0, 12 * 16); hold(1, 12 * 16); wait_idle();
        check("brk_cnt", n_brk - b0, 1);
        check("brk_stp_cnt", n_stp - t0, 1);

        // back-to-back 0x55 then 0xAA, zero idle between
        v0 = n_val; q0 = val_q.size();
        send(9'h055, 16, 8, 8, 0, 0, 0, 0, 1, 0);
        send(9'h0AA, 16, 8, 8, 0, 0, 0, 0, 1, 0);
        hold(1, 20); wait_idle();
        check("b2b_valid_cnt", n_val - v0, 2);
        if (val_q.size() >= q0 + 2) begin
            check("b2b_first", {24'd0, val_q[q0]}, 32'h55);
            check("b2b_second", {24'd0, val_q[q0 + 1]}, 32'hAA);
        end else begin
            check("b2b_queue_len", val_q.size(), q0 + 2);
        end

        // data_len out of range is treated as 8
        send(9'h0C3, 16, 8, 12, 0, 0, 0, 0, 1, 0);
        hold(1, 20); wait_idle();
        check("len12_data", {24'd0, rx_data}, 32'hC3);

        // config change mid-frame must be ignored
        v0 = n_val;
        fork
            send(9'h0E7, 16, 8, 8, 0, 0, 0, 0, 1, 0);
            begin repeat (40) @(posedge clk); #2; presc = 6'd8; len = 4'd5; pe = 1; s2 = 1; end
        join
        hold(1, 20); wait_idle();
        check("cfg_hold_data", {24'd0, rx_data}, 32'hE7);
        check("cfg_hold_valid", n_val - v0, 1);

        // 1-clock glitch at every data bit's middle sample
        send(9'h0FF, 16, 8, 8, 0, 0, 0, 0, 1, 1);
        hold(1, 20); wait_idle();
        check("glitch_data", {24'd0, rx_data}, 32'hFF);

        // reset in the middle of DATA
        v0 = n_val;
        presc = 6'd16; len = 4'd8; pe = 0; s2 = 0;
        hold(0, 16); hold(1, 16 * 3);
        rst = 1'b0; rx = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        @(posedge clk); #1;
        hold(1, 2);
        rst = 1'b1;
        hold(1, 16 * 8);
        check("midrst_valid_cnt", n_val - v0, 0);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
